// File: rtl/mod_scaler_pkg.sv
// ----------------------------------------------------------------------------
// mod_scaler_pkg
// Shared types and helpers for the pipelined modular power-of-two scaler.
//   SCALER_BITWIDTH  : operand / modulus width
//   SCALER_MAX_SHIFT : pipeline depth, i.e. the largest number of doublings
//   SHW              : width of the shift field
//   stage_t          : contents of one pipeline stage {valid, data, mod, shift}
//   mod_double()     : one modular doubling, (2*data) mod mod, for data < mod
// The stage struct widths come from this package, so operand width and depth
// are configured here; the top-level parameters default to these values.
// ----------------------------------------------------------------------------
package mod_scaler_pkg;

  localparam int SCALER_BITWIDTH  = 32;
  localparam int SCALER_MAX_SHIFT = 4;
  localparam int SHW              = $clog2(SCALER_MAX_SHIFT + 1);

  typedef struct packed {
    logic                       valid;
    logic [SCALER_BITWIDTH-1:0] data;
    logic [SCALER_BITWIDTH-1:0] mod;
    logic [SHW-1:0]             shift;
  } stage_t;

  // Doubling is done one bit wider so 2*data never overflows; with data < mod
  // a single conditional subtract brings the result back below mod.
  function automatic logic [SCALER_BITWIDTH-1:0] mod_double(
    input logic [SCALER_BITWIDTH-1:0] data,
    input logic [SCALER_BITWIDTH-1:0] mod
  );
    logic [SCALER_BITWIDTH:0] t;
    logic [SCALER_BITWIDTH:0] m;
    logic [SCALER_BITWIDTH:0] d;
    t = {data, 1'b0};
    m = {1'b0, mod};
    d = t - m;
    if (t >= m) begin
      return d[SCALER_BITWIDTH-1:0];
    end
    return t[SCALER_BITWIDTH-1:0];
  endfunction

endpackage

// File: rtl/mod_double_stage.sv
// ----------------------------------------------------------------------------
// mod_double_stage
// One registered stage of the scaler pipe. Stage STAGE_IDX doubles the data
// (mod the carried modulus) when STAGE_IDX < shift, otherwise passes it on.
// Valid, modulus and shift are carried along unchanged.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_en     : 1 = load new stage contents, 0 = hold
//   i_clr    : synchronous clear of the stage, wins over i_en
//   i_stage  : contents from the previous stage (or the inputs for stage 0)
//   o_stage  : registered contents of this stage
// ----------------------------------------------------------------------------
module mod_double_stage
  import mod_scaler_pkg::*;
#(
  parameter int STAGE_IDX = 0
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  input  logic   i_clr,
  input  stage_t i_stage,
  output stage_t o_stage
);

  localparam logic [SHW-1:0] STAGE_K = SHW'(STAGE_IDX);

  stage_t                     r_stage;
  logic                       w_doDouble;
  logic [SCALER_BITWIDTH-1:0] w_data;

  // Data of invalid samples is don't-care, so the op is not gated by valid.
  always_comb begin
    w_doDouble = (STAGE_K < i_stage.shift);
    w_data     = w_doDouble ? mod_double(i_stage.data, i_stage.mod) : i_stage.data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '0;
    end else if (i_clr) begin
      r_stage <= '0;
    end else if (i_en) begin
      r_stage.valid <= i_stage.valid;
      r_stage.data  <= w_data;
      r_stage.mod   <= i_stage.mod;
      r_stage.shift <= i_stage.shift;
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/mod_pow2_scaler_pipe.sv
// ----------------------------------------------------------------------------
// mod_pow2_scaler_pipe
// Pipelined modular power-of-two scaler: oData = (iData * 2^iShift) mod iMod.
// One modular doubling per stage, fixed latency of MAX_SHIFT enabled cycles
// regardless of iShift, one sample per enabled cycle.
// Optional feature macro: MOD_SCALER_RANGE_CHECK_EN
//   defined     : sticky oErr flags accepted samples with iData >= iMod or iMod < 2
//   not defined : oErr tied to 0
// Ports:
//   iClk    : clock, rising edge
//   iRstN   : asynchronous active-low reset
//   iEn     : 1 = pipeline advances, 0 = every register holds
//   iClr    : synchronous clear of all pipeline state (wins over iEn)
//   iValid  : input sample valid
//   iData   : operand, expected < iMod
//   iMod    : modulus, carried with the sample
//   iShift  : number of doublings; values above MAX_SHIFT saturate
//   oValid  : oData valid
//   oData   : scaled result
//   oErr    : sticky range error
// ----------------------------------------------------------------------------
module mod_pow2_scaler_pipe
  import mod_scaler_pkg::*;
#(
  parameter int BITWIDTH  = SCALER_BITWIDTH,
  parameter int MAX_SHIFT = SCALER_MAX_SHIFT
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHW-1:0]      iShift,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  localparam logic [SHW-1:0] SHIFT_MAX = SHW'(MAX_SHIFT);

  // Index 0 is the input side, index k+1 is the output of stage k.
  stage_t         w_stage [0:MAX_SHIFT];
  logic [SHW-1:0] w_shiftSat;

  // Saturating the shift at entry keeps every stage's compare in range.
  always_comb begin
    w_shiftSat       = (iShift > SHIFT_MAX) ? SHIFT_MAX : iShift;
    w_stage[0].valid = iValid;
    w_stage[0].data  = iData;
    w_stage[0].mod   = iMod;
    w_stage[0].shift = w_shiftSat;
  end

  for (genvar k = 0; k < MAX_SHIFT; k++) begin : g_stage
    mod_double_stage #(
      .STAGE_IDX (k)
    ) u_stage (
      .i_clk   (iClk),
      .i_rst_n (iRstN),
      .i_en    (iEn),
      .i_clr   (iClr),
      .i_stage (w_stage[k]),
      .o_stage (w_stage[k+1])
    );
  end

  assign oValid = w_stage[MAX_SHIFT].valid;
  assign oData  = w_stage[MAX_SHIFT].data;

`ifdef MOD_SCALER_RANGE_CHECK_EN
  logic r_err;
  logic w_rangeBad;

  // Only samples actually accepted into stage 0 can raise the flag.
  always_comb begin
    w_rangeBad = iValid && iEn && ((iData >= iMod) || (iMod < BITWIDTH'(2)));
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_err <= 1'b0;
    end else if (iClr) begin
      r_err <= 1'b0;
    end else if (w_rangeBad) begin
      r_err <= 1'b1;
    end
  end

  assign oErr = r_err;
`else
  assign oErr = 1'b0;
`endif

endmodule

// File: tb/tb_mod_pow2_scaler_pipe.sv
// ----------------------------------------------------------------------------
// tb_mod_pow2_scaler_pipe
// Self-checking bench for mod_pow2_scaler_pipe (BITWIDTH=32, MAX_SHIFT=4).
// A four-entry expectation pipe tracks what should reach the output; each
// entry's value comes from a hand-computed table or an arithmetic golden
// function (iData << iShift) % iMod. Honours MOD_SCALER_RANGE_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_mod_pow2_scaler_pipe;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mod;
    logic [2:0]  shift;
    logic [31:0] expData;
  } vector_t;

  logic        iClk;
  logic        iRstN;
  logic        iEn;
  logic        iClr;
  logic        iValid;
  logic [31:0] iData;
  logic [31:0] iMod;
  logic [2:0]  iShift;
  logic        oValid;
  logic [31:0] oData;
  logic        oErr;

  int checkCount;
  int errorCount;

  logic        expV [DEPTH];
  logic        expK [DEPTH];
  logic [31:0] expD [DEPTH];
  logic        expErr;

  vector_t vectors [12];

  mod_pow2_scaler_pipe dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iValid (iValid),
    .iData  (iData),
    .iMod   (iMod),
    .iShift (iShift),
    .oValid (oValid),
    .oData  (oData),
    .oErr   (oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [31:0] golden(input logic [31:0] d, input logic [31:0] m,
                                         input logic [2:0] s);
    int          sh;
    logic [63:0] p;
    sh = (s > 3'd4) ? 4 : int'(s);
    p  = {32'b0, d} << sh;
    return 32'(p % {32'b0, m});
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      expV[i] = 1'b0;
      expK[i] = 1'b1;
      expD[i] = '0;
    end
    expErr = 1'b0;
  endtask

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] required);
    checkCount++;
    if (actual !== required) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0d (0x%08h) required=%0d (0x%08h) at %0t",
               name, actual, actual, required, required, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".oValid"}, 32'(oValid), 32'(expV[DEPTH-1]));
    if (expK[DEPTH-1]) compare({tag, ".oData"}, oData, expD[DEPTH-1]);
    compare({tag, ".oErr"}, 32'(oErr), 32'(expErr));
  endtask

  // Drive one cycle of inputs, advance the expectation pipe at the edge,
  // then check the outputs 1 time unit after the edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] d,
                               input logic [31:0] m, input logic [2:0] s,
                               input logic [31:0] e, input logic known,
                               input logic en, input logic clr);
    iValid = v;
    iData  = d;
    iMod   = m;
    iShift = s;
    iEn    = en;
    iClr   = clr;
    @(posedge iClk);
    if (clr) begin
      modelReset();
    end else if (en) begin
`ifdef MOD_SCALER_RANGE_CHECK_EN
      if (v && ((d >= m) || (m < 32'd2))) expErr = 1'b1;
`endif
      for (int i = DEPTH - 1; i > 0; i--) begin
        expV[i] = expV[i-1];
        expK[i] = expK[i-1];
        expD[i] = expD[i-1];
      end
      expV[0] = v;
      expK[0] = known;
      expD[0] = e;
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic sendSample(input string tag, input logic [31:0] d, input logic [31:0] m,
                            input logic [2:0] s, input logic [31:0] e);
    applyStimulus(tag, 1'b1, d, m, s, e, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic sendBubble(input string tag);
    applyStimulus(tag, 1'b0, $urandom, 32'd23, 3'($urandom_range(0, 7)), '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) sendBubble(tag);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelReset();

    vectors[0]  = '{32'd7,          32'd23,         3'd2, 32'd5};
    vectors[1]  = '{32'd22,         32'd23,         3'd4, 32'd7};
    vectors[2]  = '{32'd13,         32'd23,         3'd0, 32'd13};
    vectors[3]  = '{32'd22,         32'd23,         3'd7, 32'd7};
    vectors[4]  = '{32'd0,          32'd23,         3'd3, 32'd0};
    vectors[5]  = '{32'd1,          32'd23,         3'd4, 32'd16};
    vectors[6]  = '{32'd22,         32'd23,         3'd1, 32'd21};
    vectors[7]  = '{32'd5,          32'd23,         3'd3, 32'd17};
    vectors[8]  = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  3'd1, 32'hFFFF_FFFD};
    vectors[9]  = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  3'd4, 32'hFFFF_FFEF};
    vectors[10] = '{32'd1,          32'd2,          3'd4, 32'd0};
    vectors[11] = '{32'd3,          32'd5,          3'd5, 32'd3};

    // Reset state
    iRstN  = 1'b0;
    iEn    = 1'b0;
    iClr   = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    iMod   = 32'd23;
    iShift = '0;
    #12;
    checkOutput("reset");
    @(posedge iClk);
    #2;
    iRstN = 1'b1;

    // Single sample: output appears after exactly four enabled cycles
    $display("[TB] single sample latency");
    sendSample("single", 32'd7, 32'd23, 3'd2, 32'd5);
    flush("single.drain");

    // Table vectors streamed back to back
    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      sendSample($sformatf("vec%0d", i), vectors[i].data, vectors[i].mod,
                 vectors[i].shift, vectors[i].expData);
    end
    flush("vec.drain");

    // Random stream, fixed modulus then per-sample modulus
    $display("[TB] random stream");
    for (int i = 0; i < 100; i++) begin
      logic [31:0] d;
      logic [31:0] m;
      logic [2:0]  s;
      m = (i < 50) ? 32'd23 : 32'($urandom_range(2, 1000));
      d = 32'($urandom_range(0, int'(m) - 1));
      s = 3'($urandom_range(0, 7));
      sendSample("rand", d, m, s, golden(d, m, s));
    end
    flush("rand.drain");

    // Stall mid-flight; inputs presented during the stall must be ignored
    $display("[TB] stall");
    sendSample("stall.a", 32'd3,  32'd23, 3'd1, 32'd6);
    sendSample("stall.b", 32'd12, 32'd23, 3'd2, 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall.hold", 1'b1, 32'd9, 32'd23, 3'd3, '0, 1'b0, 1'b0, 1'b0);
    end
    sendSample("stall.c", 32'd20, 32'd23, 3'd3, 32'd22);
    sendSample("stall.d", 32'd11, 32'd23, 3'd4, 32'd15);
    sendSample("stall.e", 32'd4,  32'd23, 3'd0, 32'd4);
    for (int i = 0; i < 2; i++) begin
      applyStimulus("stall.hold2", 1'b1, 32'd1, 32'd23, 3'd1, '0, 1'b0, 1'b0, 1'b0);
    end
    flush("stall.drain");

    // Clear with three samples in flight, once enabled and once stalled
    $display("[TB] clear");
    sendSample("clr.a", 32'd7, 32'd23, 3'd2, 32'd5);
    sendSample("clr.b", 32'd8, 32'd23, 3'd3, 32'd18);
    sendSample("clr.c", 32'd9, 32'd23, 3'd1, 32'd18);
    applyStimulus("clr.pulse", 1'b1, 32'd5, 32'd23, 3'd1, '0, 1'b0, 1'b1, 1'b1);
    sendSample("clr.d", 32'd10, 32'd23, 3'd2, 32'd17);
    sendSample("clr.e", 32'd2,  32'd23, 3'd3, 32'd16);
    sendSample("clr.f", 32'd6,  32'd23, 3'd4, 32'd4);
    applyStimulus("clr.noen", 1'b1, 32'd5, 32'd23, 3'd1, '0, 1'b0, 1'b0, 1'b1);
    sendSample("clr.g", 32'd21, 32'd23, 3'd1, 32'd19);
    flush("clr.drain");

    // Range error: sticky until clear (only raised with the check enabled)
    $display("[TB] range error");
    applyStimulus("err.bad", 1'b1, 32'd30, 32'd23, 3'd1, '0, 1'b0, 1'b1, 1'b0);
    sendSample("err.ok", 32'd14, 32'd23, 3'd1, 32'd5);
    flush("err.sticky");
    applyStimulus("err.clr", 1'b0, 32'd0, 32'd23, 3'd0, '0, 1'b0, 1'b1, 1'b1);
    sendBubble("err.after");

    // Asynchronous reset mid-stream
    $display("[TB] async reset");
    applyStimulus("rst.bad", 1'b1, 32'd30, 32'd23, 3'd2, '0, 1'b0, 1'b1, 1'b0);
    sendSample("rst.a", 32'd15, 32'd23, 3'd2, 32'd14);
    sendSample("rst.b", 32'd16, 32'd23, 3'd1, 32'd9);
    sendSample("rst.c", 32'd17, 32'd23, 3'd3, 32'd21);
    sendSample("rst.d", 32'd18, 32'd23, 3'd4, 32'd12);
    #2;
    iRstN = 1'b0;
    modelReset();
    #1;
    checkOutput("rst.async");
    @(posedge iClk);
    #2;
    iRstN = 1'b1;
    checkOutput("rst.release");
    sendSample("rst.e", 32'd19, 32'd23, 3'd2, 32'd7);
    flush("rst.drain");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
